frame_req_scheduler: RTL and testbench
======================================

FRAME_REQ_SCHEDULER -- requirements
Module: frame_req_scheduler

Interface
REQ-001 Parameter PERIOD_MIN, default 16, SHALL set the minimum frame-start spacing in clk_rxg cycles.
REQ-002 Parameter REQ_PULSE_LEN, default 11, SHALL set the frame_req high time in cycles.
REQ-003 clk_rxg  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst_rx_n  in  1  reset, asynchronous, active-low.
REQ-005 reg_sched_enable  in  1  level; a rising edge starts a run, low requests a graceful stop.
REQ-006 reg_sched_abort  in  1  a rising edge stops the run immediately.
REQ-007 reg_frame_period  in  24  frame-start to frame-start spacing, in cycles.
REQ-008 reg_frame_count  in  16  frames per run; 0 means continuous.
REQ-009 reg_grab_timeout  in  24  maximum wait for grab_done, in cycles; 0 disables the timeout.
REQ-010 training_done  in  1  level; the link is trained.
REQ-011 grab_done  in  1  one-cycle pulse; the current frame has been captured.
REQ-012 frame_req  out  1  frame request pulse to the sensor.
REQ-013 frames_done  out  16  frames completed in the current run.
REQ-014 sched_busy  out  1  high in any state except IDLE.
REQ-015 sched_complete  out  1  one-cycle pulse when the run reaches its frame count.
REQ-016 sched_timeout  out  1  sticky grab-timeout flag.

Function
REQ-017 Edge detection SHALL compare each register input with a one-cycle delayed copy; no other synchronisation is applied.
REQ-018 States SHALL be IDLE, REQ, WAIT_DONE and HOLDOFF, one-hot encoded.
REQ-019 IDLE -> REQ SHALL occur on a reg_sched_enable rising edge only while training_done = 1; otherwise the edge is ignored.
- On this transition the block latches period, count and timeout.
- It clears frames_done and sched_timeout.
- Latched period = max(reg_frame_period, PERIOD_MIN).
REQ-020 REQ SHALL drive frame_req = 1 for exactly REQ_PULSE_LEN cycles, starting the cycle after entry, then move to WAIT_DONE.
REQ-021 A 24-bit period counter SHALL clear on REQ entry and increment every cycle, saturating at all-ones.
REQ-022 A grab_done received in REQ or WAIT_DONE SHALL increment frames_done by 1.
- The increment wraps 65535 -> 0.
- A grab_done received in REQ ends the pulse early is not allowed; the pulse still completes before WAIT_DONE is skipped to HOLDOFF.
REQ-023 WAIT_DONE SHALL move to HOLDOFF on grab_done.
REQ-024 HOLDOFF SHALL act when the period counter >= latched period - 1, as follows:
- Return to IDLE with sched_complete pulsed if count != 0 and frames_done == count.
- Return to IDLE without a pulse if reg_sched_enable = 0.
- Otherwise re-enter REQ.
REQ-025 In WAIT_DONE, a timeout counter (cleared on REQ entry) reaching the latched timeout != 0 SHALL set sched_timeout and go to IDLE with frames_done held.
REQ-026 A reg_sched_abort rising edge in any state SHALL force IDLE on the next cycle.
- frame_req goes 0 and frames_done is held.
- If abort and grab_done coincide, abort wins and there is no increment.
REQ-027 A reg_sched_enable falling edge mid-run SHALL let the current frame finish; the stop takes effect in HOLDOFF.
REQ-028 training_done falling mid-run SHALL take no action until the next IDLE start check.
REQ-029 A grab_done received in IDLE or HOLDOFF SHALL be ignored.
REQ-030 Register inputs changing mid-run SHALL have no effect until the next start.

Reset
REQ-031 While rst_rx_n = 0, the block SHALL hold the following values:
- State IDLE.
- frame_req 0, sched_busy 0, sched_complete 0, sched_timeout 0.
- frames_done 0.
- All counters and delayed copies 0.
REQ-032 A reset asserted mid-run SHALL drop frame_req in the same cycle (asynchronous); no start is taken on the first cycle after release.

Structure
REQ-033 Package frame_sched_pkg SHALL hold the following:
- State encodings.
- Counter widths (24 and 16).
- PERIOD_MIN and REQ_PULSE_LEN defaults.
REQ-034 Rising-edge detection SHALL be a sub-module named sched_edge_det, instantiated once each for enable and abort.

Verification
REQ-035 Bench scenarios (defaults unless stated):
- Count run: period 100, count 3, training_done 1, grab_done 20 cycles after each frame_req rise -> 3 frame_req pulses of 11 cycles, rises 100 cycles apart; then sched_complete pulse, frames_done = 3, sched_busy 0.
- Period clamp: period 5, count 2 -> frame_req rises 16 cycles apart.
- Timeout: timeout 50, no grab_done -> sched_timeout = 1, frame_req rise + 50 cycles; IDLE, frames_done = 0.
- Abort: abort edge coinciding with grab_done in WAIT_DONE -> IDLE next cycle, frames_done unchanged.
- No training: enable edge with training_done 0 -> no frame_req, sched_busy 0.
- Continuous stop and reset: count 0, enable dropped mid-frame -> frame completes, then IDLE without sched_complete; rst_rx_n low during REQ -> frame_req 0 immediately.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and sizing for the frame request scheduler.
package frame_sched_pkg;

  localparam int PERIOD_W = 24;  // period, timeout and their counters
  localparam int FRAME_W  = 16;  // frame count and frames_done

  localparam int unsigned PERIOD_MIN_DEF    = 16;
  localparam int unsigned REQ_PULSE_LEN_DEF = 11;

  // One-hot scheduler states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_REQ       = 4'b0010,
    ST_WAIT_DONE = 4'b0100,
    ST_HOLDOFF   = 4'b1000
  } sched_state_e;

  // Frame period is never allowed below the configured minimum spacing
  function automatic logic [PERIOD_W-1:0] clamp_period(
    input logic [PERIOD_W-1:0] req_period,
    input logic [PERIOD_W-1:0] min_period
  );
    return (req_period < min_period) ? min_period : req_period;
  endfunction

endpackage

// File: rtl/sched_edge_det.sv
// Rising-edge detector: level compared with its one-cycle delayed copy.
module sched_edge_det (
  input  logic clk_rxg,
  input  logic rst_rx_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // Keep last cycle's level so a 0->1 change shows up for one cycle
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) sig_q <= 1'b0;
    else           sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/frame_req_scheduler.sv
// Frame request scheduler: issues fixed-length frame_req pulses at a
// programmed period, counts captured frames and stops on count, abort,
// enable drop or grab timeout.
module frame_req_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned PERIOD_MIN    = PERIOD_MIN_DEF,
  parameter int unsigned REQ_PULSE_LEN = REQ_PULSE_LEN_DEF
) (
  input  logic                clk_rxg,
  input  logic                rst_rx_n,
  input  logic                reg_sched_enable,
  input  logic                reg_sched_abort,
  input  logic [PERIOD_W-1:0] reg_frame_period,
  input  logic [FRAME_W-1:0]  reg_frame_count,
  input  logic [PERIOD_W-1:0] reg_grab_timeout,
  input  logic                training_done,
  input  logic                grab_done,
  output logic                frame_req,
  output logic [FRAME_W-1:0]  frames_done,
  output logic                sched_busy,
  output logic                sched_complete,
  output logic                sched_timeout
);

  localparam int PULSE_W = (REQ_PULSE_LEN > 1) ? $clog2(REQ_PULSE_LEN) : 1;
  localparam logic [PULSE_W-1:0]  PULSE_LAST = PULSE_W'(REQ_PULSE_LEN - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_MIN_V = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] ONE_P = PERIOD_W'(1);
  localparam logic [FRAME_W-1:0]  ONE_F = FRAME_W'(1);

  sched_state_e        state_q;
  logic                frame_req_q, busy_q, complete_q, timeout_q;
  logic [FRAME_W-1:0]  frames_done_q, count_q;
  logic [PERIOD_W-1:0] period_q, tmo_q, period_cnt_q, tmo_cnt_q;
  logic [PULSE_W-1:0]  pulse_cnt_q;
  logic                grab_seen_q;  // grab_done already arrived during REQ
  logic                armed_q;      // blocks a start on the first cycle out of reset
  logic                en_rise, abort_rise;

  sched_edge_det u_en_edge (
    .clk_rxg  (clk_rxg),
    .rst_rx_n (rst_rx_n),
    .sig_i    (reg_sched_enable),
    .rise_o   (en_rise)
  );

  sched_edge_det u_abort_edge (
    .clk_rxg  (clk_rxg),
    .rst_rx_n (rst_rx_n),
    .sig_i    (reg_sched_abort),
    .rise_o   (abort_rise)
  );

  // Scheduler FSM with its counters and registered outputs
  always_ff @(posedge clk_rxg or negedge rst_rx_n) begin
    if (!rst_rx_n) begin
      state_q       <= ST_IDLE;
      frame_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      complete_q    <= 1'b0;
      timeout_q     <= 1'b0;
      frames_done_q <= '0;
      count_q       <= '0;
      period_q      <= '0;
      tmo_q         <= '0;
      period_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
      grab_seen_q   <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      armed_q    <= 1'b1;
      complete_q <= 1'b0;
      // Free-running saturating counters; REQ entry below overrides with 0
      if (period_cnt_q != '1) period_cnt_q <= period_cnt_q + ONE_P;
      if (tmo_cnt_q != '1)    tmo_cnt_q    <= tmo_cnt_q + ONE_P;

      if (abort_rise) begin
        // Abort beats everything, including a coincident grab_done
        state_q     <= ST_IDLE;
        frame_req_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (en_rise && training_done && armed_q) begin
              period_q      <= clamp_period(reg_frame_period, PERIOD_MIN_V);
              count_q       <= reg_frame_count;
              tmo_q         <= reg_grab_timeout;
              frames_done_q <= '0;
              timeout_q     <= 1'b0;
              state_q       <= ST_REQ;
              frame_req_q   <= 1'b1;
              busy_q        <= 1'b1;
              period_cnt_q  <= '0;
              tmo_cnt_q     <= '0;
              pulse_cnt_q   <= '0;
              grab_seen_q   <= 1'b0;
            end
          end
          ST_REQ: begin
            if (grab_done) begin
              frames_done_q <= frames_done_q + ONE_F;
              grab_seen_q   <= 1'b1;
            end
            if (pulse_cnt_q == PULSE_LAST) begin
              frame_req_q <= 1'b0;
              state_q     <= (grab_seen_q || grab_done) ? ST_HOLDOFF : ST_WAIT_DONE;
            end else begin
              pulse_cnt_q <= pulse_cnt_q + 1'b1;
            end
          end
          ST_WAIT_DONE: begin
            if (grab_done) begin
              frames_done_q <= frames_done_q + ONE_F;
              state_q       <= ST_HOLDOFF;
            end else if (tmo_q != '0 && tmo_cnt_q >= tmo_q - ONE_P) begin
              timeout_q <= 1'b1;
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
            end
          end
          ST_HOLDOFF: begin
            if (period_cnt_q >= period_q - ONE_P) begin
              if (count_q != '0 && frames_done_q == count_q) begin
                complete_q <= 1'b1;
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
              end else if (!reg_sched_enable) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q      <= ST_REQ;
                frame_req_q  <= 1'b1;
                period_cnt_q <= '0;
                tmo_cnt_q    <= '0;
                pulse_cnt_q  <= '0;
                grab_seen_q  <= 1'b0;
              end
            end
          end
          default: begin
            state_q     <= ST_IDLE;
            frame_req_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_req      = frame_req_q;
  assign frames_done    = frames_done_q;
  assign sched_busy     = busy_q;
  assign sched_complete = complete_q;
  assign sched_timeout  = timeout_q;

endmodule

// File: tb/tb_frame_req_scheduler.sv
// Directed bench for frame_req_scheduler: count run, period clamp,
// grab timeout, abort, missing training, graceful stop and reset.
`timescale 1ns/1ps
module tb_frame_req_scheduler;

  logic        clk_rxg = 1'b0;
  logic        rst_rx_n = 1'b0;
  logic        reg_sched_enable = 1'b0;
  logic        reg_sched_abort = 1'b0;
  logic [23:0] reg_frame_period = 24'd100;
  logic [15:0] reg_frame_count = 16'd0;
  logic [23:0] reg_grab_timeout = 24'd0;
  logic        training_done = 1'b0;
  logic        grab_done;
  logic        frame_req;
  logic [15:0] frames_done;
  logic        sched_busy, sched_complete, sched_timeout;

  logic        grab_man = 1'b0;
  logic        grab_auto_pulse = 1'b0;
  bit          grab_auto = 1'b0;
  int          grab_delay = 20;

  assign grab_done = grab_man | grab_auto_pulse;

  always #5 clk_rxg = ~clk_rxg;

  frame_req_scheduler dut (
    .clk_rxg          (clk_rxg),
    .rst_rx_n         (rst_rx_n),
    .reg_sched_enable (reg_sched_enable),
    .reg_sched_abort  (reg_sched_abort),
    .reg_frame_period (reg_frame_period),
    .reg_frame_count  (reg_frame_count),
    .reg_grab_timeout (reg_grab_timeout),
    .training_done    (training_done),
    .grab_done        (grab_done),
    .frame_req        (frame_req),
    .frames_done      (frames_done),
    .sched_busy       (sched_busy),
    .sched_complete   (sched_complete),
    .sched_timeout    (sched_timeout)
  );

  int unsigned cyc = 0;
  always @(posedge clk_rxg) cyc <= cyc + 1;

  // Monitor: frame_req rise cycles, pulse lengths, complete pulses, timeout rise
  int unsigned rise_cyc[$];
  int unsigned pulse_len[$];
  int unsigned complete_cnt = 0;
  int unsigned tmo_rise_cyc = 0;
  int unsigned hi_len = 0;
  logic fr_prev = 1'b0, tmo_prev = 1'b0;
  always @(negedge clk_rxg) begin
    if (frame_req === 1'b1 && !fr_prev) rise_cyc.push_back(cyc);
    if (frame_req === 1'b1) hi_len++;
    else if (fr_prev) begin
      pulse_len.push_back(hi_len);
      hi_len = 0;
    end
    if (sched_complete === 1'b1) complete_cnt++;
    if (sched_timeout === 1'b1 && !tmo_prev) tmo_rise_cyc = cyc;
    fr_prev  = frame_req;
    tmo_prev = sched_timeout;
  end

  // Sensor model: one grab_done pulse grab_delay cycles after each frame_req rise
  int   grab_cd = 0;
  logic rsp_prev = 1'b0;
  always @(negedge clk_rxg) begin
    grab_auto_pulse = 1'b0;
    if (grab_cd > 0) begin
      grab_cd--;
      if (grab_cd == 0) grab_auto_pulse = 1'b1;
    end
    if (grab_auto && frame_req === 1'b1 && !rsp_prev) grab_cd = grab_delay - 1;
    rsp_prev = frame_req;
  end

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_rxg);
      #1;
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (frame_req !== 1'b1 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(frame_req), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (sched_busy !== 1'b0 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(sched_busy), 32'd0);
  endtask

  int unsigned b, bp, bc, r0, idle_cyc;

  initial begin
    // Reset values
    step(3);
    check("rst_frame_req", 32'(frame_req), 32'd0);
    check("rst_busy", 32'(sched_busy), 32'd0);
    check("rst_complete", 32'(sched_complete), 32'd0);
    check("rst_timeout", 32'(sched_timeout), 32'd0);
    check("rst_frames_done", 32'(frames_done), 32'd0);
    rst_rx_n = 1'b1;
    training_done = 1'b1;
    step(3);

    // Count run: period 100, count 3, grab 20 cycles after each rise
    b = rise_cyc.size(); bp = pulse_len.size(); bc = complete_cnt;
    reg_frame_period = 24'd100; reg_frame_count = 16'd3; reg_grab_timeout = 24'd0;
    grab_delay = 20; grab_auto = 1'b1;
    reg_sched_enable = 1'b1;
    step(2);
    check("cnt_busy_run", 32'(sched_busy), 32'd1);
    wait_idle("cnt_end", 400);
    check("cnt_rises", rise_cyc.size() - b, 32'd3);
    check("cnt_gap1", rise_cyc[b+1] - rise_cyc[b], 32'd100);
    check("cnt_gap2", rise_cyc[b+2] - rise_cyc[b+1], 32'd100);
    check("cnt_len0", pulse_len[bp], 32'd11);
    check("cnt_len1", pulse_len[bp+1], 32'd11);
    check("cnt_len2", pulse_len[bp+2], 32'd11);
    check("cnt_complete", complete_cnt - bc, 32'd1);
    check("cnt_frames_done", 32'(frames_done), 32'd3);
    check("cnt_no_timeout", 32'(sched_timeout), 32'd0);
    reg_sched_enable = 1'b0; grab_auto = 1'b0;
    step(3);

    // Period clamp: period 5 runs at the 16-cycle minimum
    b = rise_cyc.size(); bc = complete_cnt;
    reg_frame_period = 24'd5; reg_frame_count = 16'd2;
    grab_delay = 13; grab_auto = 1'b1;
    reg_sched_enable = 1'b1;
    step(2);
    wait_idle("clamp_end", 150);
    check("clamp_rises", rise_cyc.size() - b, 32'd2);
    check("clamp_gap", rise_cyc[b+1] - rise_cyc[b], 32'd16);
    check("clamp_frames_done", 32'(frames_done), 32'd2);
    check("clamp_complete", complete_cnt - bc, 32'd1);
    reg_sched_enable = 1'b0; grab_auto = 1'b0;
    step(3);

    // Grab timeout 50 with no grab_done
    reg_frame_period = 24'd100; reg_frame_count = 16'd0; reg_grab_timeout = 24'd50;
    reg_sched_enable = 1'b1;
    wait_req("tmo_start", 10);
    r0 = rise_cyc[rise_cyc.size()-1];
    wait_idle("tmo_idle", 200);
    check("tmo_flag", 32'(sched_timeout), 32'd1);
    check("tmo_latency", tmo_rise_cyc - r0, 32'd50);
    check("tmo_frames_done", 32'(frames_done), 32'd0);
    check("tmo_frame_req", 32'(frame_req), 32'd0);
    reg_sched_enable = 1'b0;
    step(3);

    // Abort coinciding with grab_done in WAIT_DONE
    reg_grab_timeout = 24'd0;
    reg_sched_enable = 1'b1;
    wait_req("abort_start", 10);
    check("abort_tmo_cleared", 32'(sched_timeout), 32'd0);
    step(15);
    grab_man = 1'b1;
    step(1);
    grab_man = 1'b0;
    check("abort_first_frame", 32'(frames_done), 32'd1);
    wait_req("abort_req2", 120);
    step(15);
    check("abort_busy_before", 32'(sched_busy), 32'd1);
    grab_man = 1'b1; reg_sched_abort = 1'b1;
    step(1);
    grab_man = 1'b0; reg_sched_abort = 1'b0;
    check("abort_busy", 32'(sched_busy), 32'd0);
    check("abort_frame_req", 32'(frame_req), 32'd0);
    check("abort_frames_held", 32'(frames_done), 32'd1);
    reg_sched_enable = 1'b0;
    step(3);

    // Enable edge without training is ignored
    training_done = 1'b0;
    b = rise_cyc.size();
    reg_sched_enable = 1'b1;
    step(30);
    check("notrain_rises", rise_cyc.size() - b, 32'd0);
    check("notrain_busy", 32'(sched_busy), 32'd0);
    training_done = 1'b1;
    step(5);
    check("notrain_late_busy", 32'(sched_busy), 32'd0);
    reg_sched_enable = 1'b0;
    step(3);

    // Continuous run, enable dropped mid-frame (grab arrives during REQ)
    bc = complete_cnt;
    reg_frame_period = 24'd40; reg_frame_count = 16'd0;
    grab_delay = 5; grab_auto = 1'b1;
    reg_sched_enable = 1'b1;
    wait_req("stop_start", 10);
    b = rise_cyc.size() - 1;
    r0 = rise_cyc[b];
    step(3);
    reg_sched_enable = 1'b0;
    reg_frame_period = 24'd200;
    step(1);
    check("stop_pulse_continues", 32'(frame_req), 32'd1);
    wait_idle("stop_idle", 100);
    idle_cyc = cyc;
    check("stop_idle_time", idle_cyc - r0, 32'd40);
    check("stop_rises", rise_cyc.size() - b, 32'd1);
    check("stop_len", pulse_len[pulse_len.size()-1], 32'd11);
    check("stop_frames_done", 32'(frames_done), 32'd1);
    check("stop_no_complete", complete_cnt - bc, 32'd0);
    grab_auto = 1'b0; reg_frame_period = 24'd100;
    step(3);

    // Reset during REQ drops frame_req at once; no start right after release
    reg_sched_enable = 1'b1;
    wait_req("rstrun_start", 10);
    step(2);
    #2 rst_rx_n = 1'b0;
    #1;
    check("rstrun_frame_req", 32'(frame_req), 32'd0);
    check("rstrun_busy", 32'(sched_busy), 32'd0);
    check("rstrun_frames_done", 32'(frames_done), 32'd0);
    b = rise_cyc.size();
    step(2);
    rst_rx_n = 1'b1;
    step(5);
    check("rstrun_no_restart", rise_cyc.size() - b, 32'd0);
    check("rstrun_busy_after", 32'(sched_busy), 32'd0);
    reg_sched_enable = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case the run never reaches its summary
  initial begin
    #500us;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
